multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have a clock `clk`, input, 1 bit, with rising-edge active.
REQ-002 The block SHALL have a reset `rst`, input, 1 bit, asynchronous and active-high.
REQ-003 `stall` input 1: SHALL freeze the FSM and gate all write enables while high (memory wait).
REQ-004 `op` input 6: SHALL carry instruction[31:26] from the IR register.
REQ-005 `funct` input 6: SHALL carry instruction[5:0].
REQ-006 `zero` input 1: SHALL carry the ALU zero flag.
REQ-007 `pcen` output 1: SHALL be the PC register enable.
REQ-008 `irwrite`, `memwrite`, `regwrite` outputs 1 each: SHALL be the IR, memory and register-file write enables.
REQ-009 `iord`, `regdst`, `memtoreg`, `alusrca` outputs 1 each: SHALL be mux selects.
REQ-010 `alusrcb` output 2, `pcsrc` output 2: SHALL be mux selects.
REQ-011 `alucontrol` output 3: SHALL be the ALU operation code.
REQ-012 `state` output 4: SHALL expose the current FSM state for debug.

Function
REQ-013 Opcodes SHALL be decoded as: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010; any other opcode is illegal.
REQ-014 The states SHALL be encoded as: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
REQ-015 The state transitions SHALL be:
- FETCH->DECODE.
- DECODE->MEMADR (lw/sw), EXECUTE (R), BRANCH (beq), ADDIEXEC (addi), JUMP (j).
- MEMADR->MEMRD (lw) or MEMWR (sw).
- MEMRD->MEMWB.
- EXECUTE->ALUWB.
- ADDIEXEC->ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP->FETCH.
REQ-016 In DECODE, an illegal opcode SHALL return the FSM to FETCH with no register, memory or PC write.
REQ-017 Encodings 12-15 SHALL be unreachable; if entered, the FSM SHALL go to FETCH on the next edge.
REQ-018 Outputs SHALL be Moore, depending on state only, except `pcen` and `alucontrol`. Unlisted signals are 0:
- FETCH: irwrite=1, pcwrite=1, alusrcb=01.
- DECODE: alusrcb=11.
- MEMADR: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: regwrite=1, memtoreg=1.
- MEMWR: iord=1, memwrite=1.
- EXECUTE: alusrca=1, aluop=10.
- ALUWB: regwrite=1, regdst=1.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
- ADDIEXEC: alusrca=1, alusrcb=10.
- ADDIWB: regwrite=1.
- JUMP: pcsrc=10, pcwrite=1.
REQ-019 `pcen` SHALL equal (pcwrite | (branch & zero)) & ~stall.
REQ-020 `alucontrol` SHALL be derived as follows:
- aluop=00 -> 010 (add); aluop=01 -> 110 (sub).
- aluop=10 with funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
- Any other funct -> 010.
REQ-021 While `stall`=1, the state SHALL hold, and irwrite, memwrite, regwrite and pcen SHALL be 0; mux selects SHALL keep their state values.
REQ-022 The instruction latency SHALL be, in cycles without stall: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-023 Each stall cycle SHALL add exactly one cycle to the latency.

Reset
REQ-024 `rst`=1 SHALL force state=FETCH immediately, independent of `clk`, including mid-instruction.
REQ-025 During reset, outputs SHALL take the FETCH decode (irwrite=1, alusrcb=01) gated to write enables 0, and pcen=0.
REQ-026 After `rst` falls, the first rising edge SHALL perform the FETCH of the first instruction.

Structure
REQ-027 Opcode, funct, state and alucontrol constants SHALL reside in the shared package `mips_defs`.
REQ-028 ALU decoding SHALL be the combinational sub-module `aludec` (aluop, funct -> alucontrol).
REQ-029 The state register SHALL be the only sequential element in the block.

Verification
REQ-030 lw (op=100011) without stall -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; pcen=1 only in state 0.
REQ-031 beq with zero=1 -> pcen=1 in state 8 with pcsrc=01 and alucontrol=110; with zero=0 -> pcen=0 in state 8.
REQ-032 R-type with funct=101010 -> alucontrol=111 in state 6, then regwrite=1 with regdst=1 in state 7.
REQ-033 op=111111 -> states 0,1,0; no write enable asserted in state 1.
REQ-034 sw with stall=1 for 3 cycles in MEMWR -> state holds at 5 and memwrite=0 for 3 cycles; memwrite=1 for exactly one cycle after stall falls.
REQ-035 rst asserted asynchronously in state 3 -> state=0 before the next edge; no regwrite is ever issued for the aborted lw.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
// Module : mips_defs (package)
// Brief  : Opcode, funct, FSM state and ALU control constants for the
//          multicycle MIPS controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// Module : multicycle_ctrl_if
// Brief  : Controller <-> datapath bundle: status inputs and control outputs.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if;
    logic       stall;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;

    logic       pcen;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    // Controller side
    modport master (
        input  stall, op, funct, zero,
        output pcen, irwrite, memwrite, regwrite, iord, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucontrol, state
    );

    // Datapath side
    modport slave (
        output stall, op, funct, zero,
        input  pcen, irwrite, memwrite, regwrite, iord, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucontrol, state
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl_aludec.sv
// ============================================================================
// Module : aludec
// Brief  : Combinational ALU decoder (aluop, funct -> alucontrol).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aludec
    import mips_defs::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module : multicycle_ctrl
// Brief  : Multicycle MIPS main controller FSM with stall gating.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import mips_defs::*;
(
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

    state_t     state_q;
    state_t     state_d;

    logic       pcwrite;
    logic       branch;
    logic       irwrite_raw;
    logic       memwrite_raw;
    logic       regwrite_raw;
    logic [1:0] aluop;
    logic [2:0] alucontrol;
    logic       gate;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_FETCH;
        else if (!bus.stall)
            state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    state_d = S_MEMWB;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            // Terminal states and the unused encodings 12-15 all fall back to FETCH
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite      = 1'b0;
        branch       = 1'b0;
        irwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        aluop        = ALUOP_ADD;
        bus.iord     = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.pcsrc    = 2'b00;
        case (state_q)
            S_FETCH: begin
                irwrite_raw = 1'b1;
                pcwrite     = 1'b1;
                bus.alusrcb = 2'b01;
            end
            S_DECODE: bus.alusrcb = 2'b11;
            S_MEMADR, S_ADDIEXEC: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            S_MEMRD: bus.iord = 1'b1;
            S_MEMWB: begin
                regwrite_raw = 1'b1;
                bus.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                memwrite_raw = 1'b1;
            end
            S_EXECUTE: begin
                bus.alusrca = 1'b1;
                aluop       = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regwrite_raw = 1'b1;
                bus.regdst   = 1'b1;
            end
            S_BRANCH: begin
                bus.alusrca = 1'b1;
                aluop       = ALUOP_SUB;
                bus.pcsrc   = 2'b01;
                branch      = 1'b1;
            end
            S_ADDIWB: regwrite_raw = 1'b1;
            S_JUMP: begin
                bus.pcsrc = 2'b10;
                pcwrite   = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset and stall both suppress every architectural write
    assign gate         = bus.stall | rst;
    assign bus.irwrite  = irwrite_raw  & ~gate;
    assign bus.memwrite = memwrite_raw & ~gate;
    assign bus.regwrite = regwrite_raw & ~gate;
    assign bus.pcen     = (pcwrite | (branch & bus.zero)) & ~gate;
    assign bus.state    = state_q;

    aludec u_aludec (
        .aluop      (aluop),
        .funct      (bus.funct),
        .alucontrol (alucontrol)
    );

    assign bus.alucontrol = alucontrol;

endmodule

`default_nettype wire
